// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: PC width, per-stage NOP payloads and the
// pipeline-stage occupancy FSM encoding.
package cpu_pkg;

    localparam int CPU_PC_W = 30;

    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
    localparam logic [95:0] NOP_IF_ID    = {64'h0, NOP_INSN};
    localparam logic [95:0] NOP_ID_EX    = 96'h0;
    localparam logic [95:0] NOP_EX_MEM   = 96'h0;
    localparam logic [95:0] NOP_MEM_WB   = 96'h0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_st_e;

endpackage

// File: rtl/cpu_pipe_slot.sv
// One holding register of a pipeline stage: load, clear-to-NOP, or hold.
module cpu_pipe_slot #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over load so a flush can never let a new entry slip in.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            q <= CLR_VAL;
        end else if (clear) begin
            q <= CLR_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu_pipe_stage.sv
// Generic inter-stage pipeline register: PC + payload with valid/ready,
// stall/flush control and an optional two-entry skid buffer.
module cpu_pipe_stage
    import cpu_pkg::*;
#(
    parameter int                 DATA_W   = 96,
    parameter int                 PC_W     = CPU_PC_W,
    parameter int                 SKID     = 1,
    parameter logic [DATA_W-1:0]  NOP_DATA = '0
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int           W         = PC_W + DATA_W;
    localparam logic [W-1:0] EMPTY_VAL = {{PC_W{1'b0}}, NOP_DATA};

    pipe_st_e     state_reg, state_next;
    logic         out_valid_reg;
    logic [1:0]   occ_reg, occ_next;
    logic         accept, pop;
    logic         head_load, head_clear, skid_load, skid_clear;
    logic [W-1:0] in_word, head_d, head_q, skid_q;

    assign in_word = {in_pc, in_data};
    assign accept  = in_valid & in_ready & ~stall;
    assign pop     = out_valid_reg & out_ready & ~stall;

    always_comb begin
        state_next = state_reg;
        head_load  = 1'b0;
        head_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        head_d     = in_word;
        if (flush) begin
            state_next = ST_EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        head_load  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        // Only reachable with the skid slot present.
                        if (SKID != 0) begin
                            skid_load  = 1'b1;
                            state_next = ST_TWO;
                        end
                    end else if (pop) begin
                        head_clear = 1'b1;
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head_d     = skid_q;
                        head_load  = 1'b1;
                        skid_clear = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        case (state_next)
            ST_ONE:  occ_next = 2'd1;
            ST_TWO:  occ_next = 2'd2;
            default: occ_next = 2'd0;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_reg     <= ST_EMPTY;
            occ_reg       <= 2'd0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            occ_reg       <= occ_next;
            out_valid_reg <= (state_next != ST_EMPTY);
        end
    end

    cpu_pipe_slot #(.W(W), .CLR_VAL(EMPTY_VAL)) u_head (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .load    (head_load),
        .clear   (head_clear),
        .d       (head_d),
        .q       (head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_reg;

            cpu_pipe_slot #(.W(W), .CLR_VAL(EMPTY_VAL)) u_skid (
                .cpu_clk (cpu_clk),
                .cpu_rst (cpu_rst),
                .load    (skid_load),
                .clear   (skid_clear),
                .d       (in_word),
                .q       (skid_q)
            );

            // Registered ready: upstream never sees out_ready combinationally.
            always_ff @(posedge cpu_clk or posedge cpu_rst) begin
                if (cpu_rst) begin
                    in_ready_reg <= 1'b0;
                end else begin
                    in_ready_reg <= ~stall & (state_next != ST_TWO);
                end
            end

            assign in_ready = in_ready_reg;
        end else begin : g_single
            assign skid_q   = EMPTY_VAL;
            assign in_ready = ~cpu_rst & ~stall & (~out_valid_reg | out_ready);
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign out_pc    = head_q[W-1:DATA_W];
    assign out_data  = head_q[DATA_W-1:0];
    assign occupancy = occ_reg;

endmodule

// File: doc/cpu_pipe_stage.md
# cpu_pipe_stage

Parametrised inter-stage pipeline register for the CPU core, generalising the fixed ID/EX register to any payload width, with valid/ready backpressure and an optional two-entry skid buffer. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a PC plus an opaque payload, honours the pipeline controller's `stall` and `flush`, and inserts NOP bubbles when empty or flushed.

## Interface
Parameters:
- `DATA_W`, 96: payload width in bits (≥1).
- `PC_W`, 30: word-address PC width.
- `SKID`, 1: 0 = single register; 1 = two-entry skid buffer (registered `in_ready`).
- `NOP_DATA`, 0: payload presented while the stage is empty or flushed.

Ports:
- `cpu_clk` in 1: the stage's single clock; all state updates on its rising edge.
- `cpu_rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream presents an entry.
- `in_ready` out 1: stage accepts an entry this cycle.
- `in_pc` in PC_W: PC of the upstream entry.
- `in_data` in DATA_W: payload of the upstream entry.
- `stall` in 1: freeze; no accept, no pop.
- `flush` in 1: discard all entries; overrides `stall`.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream takes head.
- `out_pc` out PC_W: PC of the head entry.
- `out_data` out DATA_W: payload of the head entry.
- `occupancy` out 2: number of entries held (0..2).

## Operation
- Accept when `in_valid & in_ready`; pop when `out_valid & out_ready & !stall`.
- SKID=0: single entry. `in_ready = !cpu_rst & !stall & (!out_valid | out_ready)`; push and pop in the same cycle allowed.
- SKID=1 FSM states:
  - EMPTY: accept → ONE.
  - ONE: accept without pop → TWO (entry goes to skid register); accept with pop → ONE (new entry goes to head); pop only → EMPTY.
  - TWO: pop → ONE (skid register moves to head); no accept possible.
- SKID=1 `in_ready` is a flop output: `!stall & state!=TWO` as of the next cycle. This cuts the combinational path from `out_ready` to upstream.
- `flush`: next state EMPTY. Any same-cycle accept is dropped; entries become PC 0 / `NOP_DATA`.
- `stall` without `flush`: state and contents hold. Upstream and downstream handshakes are blocked.
- When `out_valid=0`, `out_pc=0` and `out_data=NOP_DATA`. No stale data is visible.
- Order is strictly FIFO; no entry is duplicated or lost except by flush.

## Timing
- Reset value of every output: `out_valid=0`, `out_pc=0`, `out_data=NOP_DATA`, `occupancy=0`, `in_ready=0`.
  - `in_ready` rises one cycle after reset release when `stall=0`.
- Latency: an accepted entry appears at the outputs on the next edge, 1 cycle, in both modes.
- Throughput: 1 entry/cycle with `out_ready` held high.
- Simultaneous events:
  - flush+stall → flush.
  - flush+accept → entry dropped.
  - flush with `occupancy=2` → EMPTY in 1 cycle.
- Reset asserted mid-operation: all state clears immediately (asynchronously); outputs take their reset values without waiting for a clock.
- `occupancy` and `out_*` are registered; no combinational in→out data path.

## Structure
- Shared package `cpu_pkg`: `PC_W` default, `NOP_DATA` encodings per stage, and the stage-FSM enum `pipe_st_e {ST_EMPTY, ST_ONE, ST_TWO}`.
- One sub-module, `cpu_pipe_slot`: a single holding register with load, clear to NOP, and hold. Instantiate it once for SKID=0 and twice for SKID=1; the FSM stays in the top.

## Test plan
- Reset then idle → all outputs at reset values; `in_ready=1` one cycle after `cpu_rst` falls.
- Stream PCs 0x10..0x17 with `out_ready=1` → outputs 0x10..0x17 in order, 1-cycle latency, no gaps.
- SKID=1: fill with 0x20 and 0x21, then `out_ready=0` → `occupancy=2`, `in_ready=0`; release `out_ready` → 0x20 then 0x21.
- `stall` for 3 cycles with `occupancy=1` → outputs frozen and no accept; entry pops after `stall` falls.
- `flush` together with `stall` and `in_valid` at `occupancy=2` → next cycle `out_valid=0`, `out_data=NOP_DATA`, `occupancy=0`.
- Assert `cpu_rst` between clock edges while full → outputs at reset values immediately; the next accepted entry appears cleanly one cycle after it is accepted.
